// File: rtl/ahb_fabric_n.sv
// AHB-Lite single-master fabric: address-field decode to NPORT slaves,
// built-in ERROR default slave, per-port data-phase watchdog, hung flags.
module ahb_fabric_n #(
   parameter int NPORT   = 3,
   parameter int SEL_LSB = 12,
   parameter int SEL_W   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [31:0]           ahb_s0_haddr_i,
   input  logic                  ahb_s0_hwrite_i,
   input  logic [2:0]            ahb_s0_hsize_i,
   input  logic [2:0]            ahb_s0_hburst_i,
   input  logic [3:0]            ahb_s0_hprot_i,
   input  logic [1:0]            ahb_s0_htrans_i,
   input  logic                  ahb_s0_hmastlock_i,
   input  logic [31:0]           ahb_s0_hwdata_i,
   output logic                  ahb_s0_hready_o,
   output logic                  ahb_s0_hresp_o,
   output logic [31:0]           ahb_s0_hrdata_o,
   output logic [NPORT*32-1:0]   ahb_m_haddr_o,
   output logic [NPORT-1:0]      ahb_m_hwrite_o,
   output logic [NPORT*3-1:0]    ahb_m_hsize_o,
   output logic [NPORT*3-1:0]    ahb_m_hburst_o,
   output logic [NPORT*4-1:0]    ahb_m_hprot_o,
   output logic [NPORT*2-1:0]    ahb_m_htrans_o,
   output logic [NPORT-1:0]      ahb_m_hmastlock_o,
   output logic [NPORT*32-1:0]   ahb_m_hwdata_o,
   input  logic [NPORT-1:0]      ahb_m_hready_i,
   input  logic [NPORT-1:0]      ahb_m_hresp_i,
   input  logic [NPORT*32-1:0]   ahb_m_hrdata_i,
   output logic [NPORT-1:0]      hung_o,
   input  logic [NPORT-1:0]      hung_clr_i
);

   localparam logic [2:0] D_NONE = 3'd0;
   localparam logic [2:0] D_PORT = 3'd1;
   localparam logic [2:0] D_DEF  = 3'd2;
   localparam logic [2:0] D_ERR1 = 3'd3;
   localparam logic [2:0] D_ERR2 = 3'd4;

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WLAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

   logic [2:0]       dkind;
   logic [PW-1:0]    dport;
   logic [WW-1:0]    wcnt;
   logic [SEL_W-1:0] sel;
   logic             hit;
   logic [PW-1:0]    hit_port;
   logic             p_rdy;
   logic             p_resp;
   logic [31:0]      p_rdata;
   logic             tmo;
   logic             accepted;
   logic [NPORT-1:0] hung_set;

   assign sel = ahb_s0_haddr_i[SEL_LSB +: SEL_W];

   // A hung port falls through to the default slave until software clears it
   always_comb begin
      hit = 1'b0;
      hit_port = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (sel == SEL_W'(p) && !hung_o[p]) begin
            hit = 1'b1;
            hit_port = PW'(p);
         end
      end
   end

   assign ahb_m_haddr_o     = {NPORT{ahb_s0_haddr_i}};
   assign ahb_m_hwrite_o    = {NPORT{ahb_s0_hwrite_i}};
   assign ahb_m_hsize_o     = {NPORT{ahb_s0_hsize_i}};
   assign ahb_m_hburst_o    = {NPORT{ahb_s0_hburst_i}};
   assign ahb_m_hprot_o     = {NPORT{ahb_s0_hprot_i}};
   assign ahb_m_hmastlock_o = {NPORT{ahb_s0_hmastlock_i}};
   assign ahb_m_hwdata_o    = {NPORT{ahb_s0_hwdata_i}};

   for (genvar p = 0; p < NPORT; p++) begin : g_trans
      assign ahb_m_htrans_o[p*2 +: 2] =
         (hit && hit_port == PW'(p) && ahb_s0_hready_o) ?
         ahb_s0_htrans_i : 2'b00;
   end

   always_comb begin
      p_rdy = 1'b1;
      p_resp = 1'b0;
      p_rdata = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (dport == PW'(p)) begin
            p_rdy = ahb_m_hready_i[p];
            p_resp = ahb_m_hresp_i[p];
            p_rdata = ahb_m_hrdata_i[p*32 +: 32];
         end
      end
   end

   always_comb begin
      ahb_s0_hready_o = 1'b1;
      ahb_s0_hresp_o = 1'b0;
      ahb_s0_hrdata_o = '0;
      case (dkind)
         D_PORT: begin
            ahb_s0_hready_o = p_rdy;
            ahb_s0_hresp_o = p_resp;
            ahb_s0_hrdata_o = p_rdata;
         end
         D_DEF, D_ERR1: begin
            ahb_s0_hready_o = 1'b0;
            ahb_s0_hresp_o = 1'b1;
         end
         D_ERR2: begin
            ahb_s0_hresp_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign accepted = ahb_s0_htrans_i[1] && ahb_s0_hready_o;
   assign tmo = (TIMEOUT > 0) && dkind == D_PORT && !p_rdy && wcnt == WLAST;

   always_comb begin
      hung_set = '0;
      for (int p = 0; p < NPORT; p++)
         hung_set[p] = tmo && dport == PW'(p);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dkind <= D_NONE;
         dport <= '0;
         wcnt <= '0;
         hung_o <= '0;
      end else begin
         hung_o <= (hung_o & ~hung_clr_i) | hung_set;
         if (ahb_s0_hready_o) begin
            if (accepted) begin
               dkind <= hit ? D_PORT : D_DEF;
               dport <= hit_port;
            end else begin
               dkind <= D_NONE;
            end
         end else if (dkind == D_DEF || dkind == D_ERR1) begin
            dkind <= D_ERR2;
         end else if (tmo) begin
            dkind <= D_ERR1;
         end
         if (TIMEOUT > 0 && dkind == D_PORT && !p_rdy && !tmo)
            wcnt <= wcnt + WW'(1);
         else
            wcnt <= '0;
      end
   end

endmodule

// File: tb/tb_ahb_fabric_n.sv
// Bench for ahb_fabric_n: behavioural slaves per port, response
// scoreboard queue, one task per scenario.
module tb_ahb_fabric_n;

   localparam int NP = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic [31:0]   haddr;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [2:0]    hburst;
   logic [3:0]    hprot;
   logic [1:0]    htrans;
   logic          hmastlock;
   logic [31:0]   hwdata;
   logic          hready_o;
   logic          hresp_o;
   logic [31:0]   hrdata_o;
   logic [NP*32-1:0] m_haddr;
   logic [NP-1:0]    m_hwrite;
   logic [NP*3-1:0]  m_hsize;
   logic [NP*3-1:0]  m_hburst;
   logic [NP*4-1:0]  m_hprot;
   logic [NP*2-1:0]  m_htrans;
   logic [NP-1:0]    m_hmastlock;
   logic [NP*32-1:0] m_hwdata;
   logic [NP-1:0]    m_hready = '1;
   logic [NP-1:0]    m_hresp = '0;
   logic [NP*32-1:0] m_hrdata = '0;
   logic [NP-1:0]    hung;
   logic [NP-1:0]    hung_clr;

   ahb_fabric_n #(.NPORT(NP), .SEL_LSB(12), .SEL_W(4), .TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn),
      .ahb_s0_haddr_i(haddr), .ahb_s0_hwrite_i(hwrite),
      .ahb_s0_hsize_i(hsize), .ahb_s0_hburst_i(hburst),
      .ahb_s0_hprot_i(hprot), .ahb_s0_htrans_i(htrans),
      .ahb_s0_hmastlock_i(hmastlock), .ahb_s0_hwdata_i(hwdata),
      .ahb_s0_hready_o(hready_o), .ahb_s0_hresp_o(hresp_o),
      .ahb_s0_hrdata_o(hrdata_o),
      .ahb_m_haddr_o(m_haddr), .ahb_m_hwrite_o(m_hwrite),
      .ahb_m_hsize_o(m_hsize), .ahb_m_hburst_o(m_hburst),
      .ahb_m_hprot_o(m_hprot), .ahb_m_htrans_o(m_htrans),
      .ahb_m_hmastlock_o(m_hmastlock), .ahb_m_hwdata_o(m_hwdata),
      .ahb_m_hready_i(m_hready), .ahb_m_hresp_i(m_hresp),
      .ahb_m_hrdata_i(m_hrdata),
      .hung_o(hung), .hung_clr_i(hung_clr)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        resp;
   } exp_t;

   exp_t exp_q[$];
   int n_chk = 0;
   int n_err = 0;

   // Slave model: wst waits per transfer, hang = never ready
   int wst [NP] = '{0, 0, 0};
   bit hang [NP] = '{0, 0, 0};
   bit dph [NP] = '{0, 0, 0};
   int left [NP] = '{0, 0, 0};
   bit acc_s [NP] = '{0, 0, 0};
   bit done_s [NP] = '{0, 0, 0};
   int ntr [NP] = '{0, 0, 0};

   always @(negedge clk) begin
      for (int p = 0; p < NP; p++) begin
         acc_s[p] = m_htrans[p*2+1] && hready_o;
         done_s[p] = dph[p] && hready_o;
         if (m_htrans[p*2 +: 2] != 2'b00) ntr[p]++;
      end
   end

   always @(posedge clk) begin
      #1;
      for (int p = 0; p < NP; p++) begin
         if (!resetn) dph[p] = 1'b0;
         else if (acc_s[p]) begin
            dph[p] = 1'b1;
            left[p] = wst[p];
         end else if (dph[p] && done_s[p]) dph[p] = 1'b0;
         else if (dph[p] && !hang[p] && left[p] > 0) left[p]--;
         m_hready[p] = !dph[p] || (!hang[p] && left[p] == 0);
         m_hrdata[p*32 +: 32] = dph[p] ? (32'hA5A5_0000 | 32'(p)) : 32'h0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_ph(input logic [31:0] a, input logic w);
      haddr = a;
      hwrite = w;
      htrans = 2'b10;
   endtask

   task automatic clr_ntr();
      for (int p = 0; p < NP; p++) ntr[p] = 0;
   endtask

   task automatic test_reset();
      exp_t e;
      int waits;
      bit done;
      resetn = 1'b0;
      step();
      @(negedge clk);
      n_chk++;
      if ({hready_o, hresp_o} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_resp: got %b required 10", {hready_o, hresp_o});
      end
      n_chk++;
      if (hrdata_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rdata: got %h required 0", hrdata_o);
      end
      n_chk++;
      if (m_htrans !== 6'b0 || hung !== 3'b0) begin
         n_err++;
         $display("FAIL reset_idle: htrans %b hung %b required 0", m_htrans, hung);
      end
      step();
      resetn = 1'b1;
      wst[1] = 2;
      step();
      clr_ntr();
      addr_ph(32'h0000_1004, 1'b0);
      exp_q.push_back('{32'hA5A5_0001, 1'b0});
      @(negedge clk);
      n_chk++;
      if (m_htrans !== 6'b00_10_00) begin
         n_err++;
         $display("FAIL rd1_htrans: got %b required 001000", m_htrans);
      end
      waits = 0;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         step();
         htrans = 2'b00;
         @(negedge clk);
         if (hready_o) done = 1;
         else waits++;
      end
      n_chk++;
      if (!done) begin
         n_err++;
         $display("FAIL rd1_timeout: got no hready required hready");
      end else begin
         e = exp_q.pop_front();
         n_chk++;
         if (hrdata_o !== e.data || hresp_o !== e.resp) begin
            n_err++;
            $display("FAIL rd1_data: got %h/%b required %h/%b", hrdata_o, hresp_o, e.data, e.resp);
         end
      end
      n_chk++;
      if (waits !== 2) begin
         n_err++;
         $display("FAIL rd1_waits: got %0d required 2", waits);
      end
      n_chk++;
      if (ntr[0] !== 0 || ntr[1] !== 1 || ntr[2] !== 0) begin
         n_err++;
         $display("FAIL rd1_ntr: got %0d %0d %0d required 0 1 0", ntr[0], ntr[1], ntr[2]);
      end
   endtask

   task automatic test_pipelined();
      logic [31:0] wd [3] = '{32'h11, 32'h22, 32'h33};
      exp_t e;
      wst[1] = 0;
      step();
      clr_ntr();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         if (i < 3) addr_ph(32'(i) * 32'h1000, 1'b1);
         else htrans = 2'b00;
         hwdata = (i > 0) ? wd[i-1] : 32'h0;
         @(negedge clk);
         if (i > 0) begin
            n_chk++;
            if (hready_o !== 1'b1) begin
               n_err++;
               $display("FAIL pipe_bubble%0d: got hready %b required 1", i, hready_o);
            end
            e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
            n_chk++;
            if (m_hwdata[(i-1)*32 +: 32] !== e.data || hresp_o !== e.resp) begin
               n_err++;
               $display("FAIL pipe_wdata%0d: got %h/%b required %h/%b", i,
                        m_hwdata[(i-1)*32 +: 32], hresp_o, e.data, e.resp);
            end
         end
         if (i < 3) exp_q.push_back('{wd[i], 1'b0});
      end
      n_chk++;
      if (ntr[0] !== 1 || ntr[1] !== 1 || ntr[2] !== 1) begin
         n_err++;
         $display("FAIL pipe_ntr: got %0d %0d %0d required 1 1 1", ntr[0], ntr[1], ntr[2]);
      end
   endtask

   task automatic test_unmapped();
      exp_t e;
      step();
      clr_ntr();
      addr_ph(32'h0000_3000, 1'b0);
      exp_q.push_back('{32'h0, 1'b1});
      @(negedge clk);
      n_chk++;
      if (m_htrans !== 6'b0) begin
         n_err++;
         $display("FAIL unm_htrans: got %b required 0", m_htrans);
      end
      step();
      htrans = 2'b00;
      @(negedge clk);
      n_chk++;
      if ({hready_o, hresp_o} !== 2'b01) begin
         n_err++;
         $display("FAIL unm_first: got %b required 01", {hready_o, hresp_o});
      end
      step();
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (hready_o !== 1'b1 || hresp_o !== e.resp || hrdata_o !== e.data) begin
         n_err++;
         $display("FAIL unm_second: got %b/%b/%h required 1/%b/%h",
                  hready_o, hresp_o, hrdata_o, e.resp, e.data);
      end
      n_chk++;
      if (ntr[0] + ntr[1] + ntr[2] !== 0) begin
         n_err++;
         $display("FAIL unm_ntr: got %0d required 0", ntr[0] + ntr[1] + ntr[2]);
      end
   endtask

   task automatic test_watchdog();
      exp_t e;
      int waits;
      bit done;
      hang[2] = 1;
      step();
      clr_ntr();
      addr_ph(32'h0000_2000, 1'b0);
      exp_q.push_back('{32'h0, 1'b1});
      @(negedge clk);
      n_chk++;
      if (m_htrans !== 6'b10_00_00) begin
         n_err++;
         $display("FAIL wd_htrans: got %b required 100000", m_htrans);
      end
      waits = 0;
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         step();
         htrans = 2'b00;
         @(negedge clk);
         if (hresp_o) done = 1;
         else waits++;
      end
      n_chk++;
      if (!done || waits !== 8) begin
         n_err++;
         $display("FAIL wd_waits: got %0d (done %b) required 8", waits, done);
      end
      n_chk++;
      if (hready_o !== 1'b0 || hung !== 3'b100) begin
         n_err++;
         $display("FAIL wd_err1: got hready %b hung %b required 0 100", hready_o, hung);
      end
      step();
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (hready_o !== 1'b1 || hresp_o !== e.resp) begin
         n_err++;
         $display("FAIL wd_err2: got %b/%b required 1/%b", hready_o, hresp_o, e.resp);
      end
      hang[2] = 0;
      step();
      clr_ntr();
      addr_ph(32'h0000_2000, 1'b0);
      @(negedge clk);
      step();
      htrans = 2'b00;
      @(negedge clk);
      n_chk++;
      if ({hready_o, hresp_o} !== 2'b01) begin
         n_err++;
         $display("FAIL hung_acc1: got %b required 01", {hready_o, hresp_o});
      end
      step();
      @(negedge clk);
      n_chk++;
      if ({hready_o, hresp_o} !== 2'b11 || ntr[2] !== 0) begin
         n_err++;
         $display("FAIL hung_acc2: got %b ntr %0d required 11 0", {hready_o, hresp_o}, ntr[2]);
      end
   endtask

   task automatic test_hung_clear();
      exp_t e;
      int bad;
      step();
      hung_clr = 3'b100;
      @(negedge clk);
      step();
      hung_clr = 3'b000;
      @(negedge clk);
      n_chk++;
      if (hung !== 3'b000) begin
         n_err++;
         $display("FAIL clr_hung: got %b required 000", hung);
      end
      wst[2] = 0;
      step();
      addr_ph(32'h0000_2000, 1'b0);
      exp_q.push_back('{32'hA5A5_0002, 1'b0});
      @(negedge clk);
      n_chk++;
      if (m_htrans !== 6'b10_00_00) begin
         n_err++;
         $display("FAIL clr_htrans: got %b required 100000", m_htrans);
      end
      step();
      htrans = 2'b00;
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (hready_o !== 1'b1 || hrdata_o !== e.data || hresp_o !== e.resp) begin
         n_err++;
         $display("FAIL clr_read: got %b/%h/%b required 1/%h/%b",
                  hready_o, hrdata_o, hresp_o, e.data, e.resp);
      end
      hang[2] = 1;
      step();
      addr_ph(32'h0000_2000, 1'b0);
      @(negedge clk);
      bad = 0;
      for (int w = 1; w <= 8; w++) begin
         step();
         htrans = 2'b00;
         hung_clr = (w == 8) ? 3'b100 : 3'b000;
         @(negedge clk);
         if (hready_o !== 1'b0) bad++;
      end
      step();
      hung_clr = 3'b000;
      @(negedge clk);
      n_chk++;
      if (bad !== 0 || hung !== 3'b100 || {hready_o, hresp_o} !== 2'b01) begin
         n_err++;
         $display("FAIL setclr: got bad %0d hung %b resp %b required 0 100 01",
                  bad, hung, {hready_o, hresp_o});
      end
      step();
      @(negedge clk);
      hang[2] = 0;
   endtask

   task automatic test_reset_mid();
      wst[0] = 5;
      step();
      addr_ph(32'h0000_0000, 1'b0);
      @(negedge clk);
      step();
      htrans = 2'b00;
      @(negedge clk);
      n_chk++;
      if (hready_o !== 1'b0) begin
         n_err++;
         $display("FAIL mid_wait: got hready %b required 0", hready_o);
      end
      #2;
      resetn = 1'b0;
      #1;
      exp_q.delete();
      n_chk++;
      if ({hready_o, hresp_o} !== 2'b10 || hrdata_o !== 32'h0) begin
         n_err++;
         $display("FAIL mid_resp: got %b/%h required 10/0", {hready_o, hresp_o}, hrdata_o);
      end
      n_chk++;
      if (hung !== 3'b000) begin
         n_err++;
         $display("FAIL mid_hung: got %b required 000", hung);
      end
      step();
      step();
      resetn = 1'b1;
      wst[0] = 0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      haddr = '0;
      hwrite = 1'b0;
      hsize = 3'b010;
      hburst = 3'b000;
      hprot = 4'b0011;
      htrans = 2'b00;
      hmastlock = 1'b0;
      hwdata = '0;
      hung_clr = '0;
      test_reset();
      test_pipelined();
      test_unmapped();
      test_watchdog();
      test_hung_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_fabric_n.md
# ahb_fabric_n

Parametrised AHB-Lite single-master fabric that routes one upstream master to `NPORT` downstream slave ports. It replaces the fixed three-port interconnect between `cpu_core` and the peripheral units (camera/GPIO, NPU, output unit). Port selection uses an address-field decode. Beyond routing, it adds:
- a built-in default slave that returns ERROR for unmapped addresses;
- a per-port data-phase watchdog;
- sticky per-port hung flags, cleared by software.

## Interface
Parameters:
- `NPORT`, 3: number of downstream ports, 1..15.
- `SEL_LSB`, 12: lowest address bit of the port-select field.
- `SEL_W`, 4: width of the select field, haddr[SEL_LSB+SEL_W-1:SEL_LSB]; requires 2^SEL_W > NPORT.
- `TIMEOUT`, 1024: consecutive data-phase wait cycles before abort; 0 disables the watchdog.

Ports (clock and reset first):
- `clk` input 1: single clock for the block.
- `resetn` input 1: asynchronous, active-low reset.
- `ahb_s0_haddr_i` input 32, `ahb_s0_hwrite_i` input 1, `ahb_s0_hsize_i` input 3, `ahb_s0_hburst_i` input 3, `ahb_s0_hprot_i` input 4, `ahb_s0_htrans_i` input 2, `ahb_s0_hmastlock_i` input 1, `ahb_s0_hwdata_i` input 32: upstream master request.
- `ahb_s0_hready_o` output 1, `ahb_s0_hresp_o` output 1, `ahb_s0_hrdata_o` output 32: upstream response.
- `ahb_m_haddr_o` output NPORT*32, `ahb_m_hwrite_o` output NPORT, `ahb_m_hsize_o` output NPORT*3, `ahb_m_hburst_o` output NPORT*3, `ahb_m_hprot_o` output NPORT*4, `ahb_m_htrans_o` output NPORT*2, `ahb_m_hmastlock_o` output NPORT, `ahb_m_hwdata_o` output NPORT*32: downstream requests. Port p occupies slice [p*W +: W].
- `ahb_m_hready_i` input NPORT, `ahb_m_hresp_i` input NPORT, `ahb_m_hrdata_i` input NPORT*32: downstream responses.
- `hung_o` output NPORT: sticky watchdog-abort flag per port.
- `hung_clr_i` input NPORT: one-cycle pulse clears the corresponding `hung_o` bit.

## Operation
- **Address decode:** `sel` = haddr select field.
  - `sel` < NPORT and hung_o[sel]=0: port `sel`.
  - Otherwise: DEFAULT.
- **Broadcast:** haddr, hwrite, hsize, hburst, hprot, hmastlock and hwdata go unchanged to all ports.
- **htrans gating:** a port's htrans equals ahb_s0_htrans_i only when that port is decoded and ahb_s0_hready_o=1. Otherwise it is IDLE (2'b00).
- **Slave contract:** a downstream slave accepts an address phase whenever it sees a non-IDLE htrans.
- **Accepted transfer:** htrans[1]=1 and ahb_s0_hready_o=1.
- **Data-phase register `dsel`:** states NONE, PORT(p), DEFAULT, ERR1, ERR2.
  - Updates only when ahb_s0_hready_o=1.
  - Accepted transfer: next `dsel` = decoded target.
  - IDLE/BUSY: next `dsel` = NONE.
- **Response mux (hready, hresp, hrdata):**
  - NONE: 1, 0, 0.
  - PORT(p): hready_i[p], hresp_i[p], hrdata_i[p].
  - DEFAULT/ERR1: 0, 1, 0.
  - ERR2: 1, 1, 0.
- **Default slave:** DEFAULT -> ERR2 unconditionally on the next cycle, giving the AHB two-cycle ERROR response. ERR1 behaves the same (ERR1 -> ERR2).
- **Watchdog (TIMEOUT>0):**
  - Counter `wcnt` increments while `dsel`=PORT(p) and hready_i[p]=0.
  - `wcnt` clears on any other cycle.
  - When `wcnt` reaches TIMEOUT-1 with hready_i[p] still 0: `dsel` becomes ERR1, hung_o[p] is set, `wcnt` clears.
  - The fabric then completes the aborted transfer with ERROR. The slave's later response is ignored.
- **Hung port:** decodes as DEFAULT until cleared, so accesses to it get ERROR.
- **Hung flag clear:** hung_clr_i[p] clears hung_o[p]. If set and clear occur in the same cycle, set wins.
- **Width rules:** `wcnt` width is $clog2(TIMEOUT+1). Select comparison is unsigned.

## Timing
- **Reset values (resetn=0):**
  - State: `dsel`=NONE, `wcnt`=0, hung_o=0.
  - Therefore ahb_s0_hready_o=1, hresp_o=0, hrdata_o=0.
  - All downstream htrans are IDLE because they are gated by ahb_s0_hready_o and decode. Broadcast outputs follow their inputs.
- **Request path** (upstream to downstream): combinational, 0 cycles.
- **Response path:** registered `dsel`, combinational mux, 0 added wait states.
- **Back-to-back transfers to different ports:** no bubble.
- **Unmapped access:** exactly 2 data-phase cycles, hready 0 then 1, hresp high in both.
- **Watchdog abort:**
  - After TIMEOUT wait cycles, the next 2 cycles are ERR1 then ERR2.
  - hung_o rises on the first ERR1 cycle.
- **Reset mid-transfer:** asserting resetn low returns `dsel` to NONE immediately (asynchronously). Pending responses are dropped.

## Test plan
- **Reset:** reset, then NONSEQ read 0x0000_1004 with port 1 returning 0xA5A5_0001 after 2 waits -> only m_htrans[1] non-IDLE for 1 cycle; upstream sees 2 waits, then hrdata=0xA5A5_0001, hresp=0.
- **Pipelined ports:** pipelined writes to 0x0000, 0x1000, 0x2000 -> each port sees exactly one NONSEQ; hwdata 0x11, 0x22, 0x33 aligned with each data phase; no bubble cycles.
- **Unmapped access:** read 0x0000_3000 with NPORT=3 -> no port sees non-IDLE htrans; upstream sees hready=0/hresp=1, then hready=1/hresp=1.
- **Watchdog:** TIMEOUT=8, port 2 holds hready_i=0 forever -> after 8 wait cycles, ERROR in 2 cycles; hung_o=3'b100; the next access to 0x2000 gets an ERROR response and port 2 sees no htrans.
- **Hung clear:** pulse hung_clr_i[2] -> hung_o=0; an access to 0x2000 now reaches port 2. Set and clear in the same cycle -> hung_o[2] stays 1.
- **Reset mid-wait:** assert resetn during a port-0 wait state -> ahb_s0_hready_o=1 and hresp=0 immediately; hung_o=0.
